// File: rtl/hello_world_burst_avalon.sv
//------------------------------------------------------------------------------
// Module      : hello_world_burst_avalon
// Description : Avalon-MM AFU that writes a programmable number of
//               "Hello world!" lines to host memory in multi-beat bursts.
//               Exposes a DFH, AFU ID and control/status CSRs on the 64-bit
//               MMIO slave. Only the write side of the host channel is used.
//               Optional feature macro: HELLO_WORLD_DONE_FLAG_EN
//               (adds a single-beat completion flag write at base+count).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hello_world_burst_avalon #(
  parameter int ADDR_WIDTH  = 42,
  parameter int DATA_WIDTH  = 512,
  parameter int MAX_BURST   = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  // MMIO CSR slave
  input  logic [15:0]                   mmio_address,
  input  logic                          mmio_read,
  input  logic                          mmio_write,
  input  logic [63:0]                   mmio_writedata,
  input  logic [7:0]                    mmio_user,
  output logic                          mmio_waitrequest,
  output logic                          mmio_readdatavalid,
  output logic [63:0]                   mmio_readdata,
  output logic [7:0]                    mmio_readresponseuser,
  output logic [7:0]                    mmio_writeresponseuser,
  output logic                          mmio_writeresponsevalid,
  // Host memory write channel
  output logic                          wr_write,
  output logic [ADDR_WIDTH-1:0]         wr_address,
  output logic [$clog2(MAX_BURST):0]    wr_burstcount,
  output logic [DATA_WIDTH-1:0]         wr_writedata,
  output logic [DATA_WIDTH/8-1:0]       wr_byteenable,
  input  logic                          wr_waitrequest,
  // Host memory read channel (unused)
  output logic                          rd_read
);

  localparam int c_BC_W = $clog2(MAX_BURST) + 1;

  localparam logic [63:0]  c_DFH       = 64'h1000_0100_0000_0000;
  localparam logic [63:0]  c_AFU_ID_L  = 64'h9722_d433_75b6_1c66;
  localparam logic [63:0]  c_AFU_ID_H  = 64'h850a_dcc2_6ceb_4b22;
  localparam logic [103:0] c_HELLO     = 104'h0021646c726f77206f6c6c6548;
`ifdef HELLO_WORLD_DONE_FLAG_EN
  localparam logic [31:0]  c_FLAG_WORD = 32'h600D_F00D;
`endif

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_BURST = 2'd1;
`ifdef HELLO_WORLD_DONE_FLAG_EN
  localparam logic [1:0] c_FLAG  = 2'd2;
`endif
  localparam logic [1:0] c_DONE  = 2'd3;

  // State and CSR registers
  logic [1:0]             r_state;
  logic                   r_done;
  logic [ADDR_WIDTH-1:0]  r_base;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] r_lines_written;
  logic [c_BC_W-1:0]      r_beats_left;

  // Write channel output registers
  logic                   r_wr_write;
  logic [ADDR_WIDTH-1:0]  r_wr_address;
  logic [c_BC_W-1:0]      r_wr_burstcount;

  // MMIO response registers
  logic                   r_rd_valid;
  logic [63:0]            r_rd_data;
  logic [7:0]             r_rd_user;
  logic                   r_wr_resp_valid;
  logic [7:0]             r_wr_resp_user;

  logic                   w_busy;
  logic                   w_accept;
  logic                   w_start;
  logic                   w_base_wr;
  logic [COUNT_WIDTH-1:0] w_new_count;
  logic [COUNT_WIDTH-1:0] w_lw_next;
  logic [COUNT_WIDTH-1:0] w_remaining;
  logic [63:0]            w_rdata;
  logic [DATA_WIDTH-1:0]  w_beat_data;
  logic                   w_unused;

  // Beats in the next burst: whatever is left, capped at MAX_BURST.
  function automatic logic [c_BC_W-1:0] f_burst_len(input logic [COUNT_WIDTH-1:0] rem);
    if (rem >= COUNT_WIDTH'(MAX_BURST)) begin
      return c_BC_W'(MAX_BURST);
    end
    return c_BC_W'(rem);
  endfunction

  assign w_busy      = (r_state != c_IDLE);
  assign w_accept    = r_wr_write && !wr_waitrequest;
  // Control writes are only honoured while idle.
  assign w_start     = mmio_write && (mmio_address[2:0] == 3'd1) && !w_busy;
  assign w_base_wr   = mmio_write && (mmio_address[2:0] == 3'd0) && !w_busy;
  assign w_new_count = COUNT_WIDTH'(mmio_writedata);
  assign w_lw_next   = r_lines_written + COUNT_WIDTH'(1);
  assign w_remaining = r_count - w_lw_next;

  assign mmio_waitrequest        = 1'b0;
  assign mmio_readdatavalid      = r_rd_valid;
  assign mmio_readdata           = r_rd_data;
  assign mmio_readresponseuser   = r_rd_user;
  assign mmio_writeresponsevalid = r_wr_resp_valid;
  assign mmio_writeresponseuser  = r_wr_resp_user;

  assign wr_write      = r_wr_write;
  assign wr_address    = r_wr_address;
  assign wr_burstcount = r_wr_burstcount;
  assign wr_writedata  = w_beat_data;
  assign wr_byteenable = '1;
  assign rd_read       = 1'b0;

  // Upper address bits and unused write-data bits are don't-care.
  assign w_unused = &{1'b0, mmio_address[15:3], mmio_writedata};

  // CSR read mux, evaluated against the state at request time.
  always_comb begin
    w_rdata = '0;
    case (mmio_address[2:0])
      3'd0:    w_rdata = c_DFH;
      3'd1:    w_rdata = c_AFU_ID_L;
      3'd2:    w_rdata = c_AFU_ID_H;
      3'd5:    w_rdata = {w_busy, r_done, 30'b0, 32'(r_lines_written)};
      default: w_rdata = '0;
    endcase
  end

  // Beat payload; derived from accepted-beat count so it holds under stall.
  always_comb begin
    w_beat_data = '0;
`ifdef HELLO_WORLD_DONE_FLAG_EN
    if (r_state == c_FLAG) begin
      w_beat_data[31:0]  = c_FLAG_WORD;
      w_beat_data[63:32] = 32'(r_count);
    end else
`endif
    begin
      w_beat_data[103:0]              = c_HELLO;
      w_beat_data[DATA_WIDTH-1 -: 32] = 32'(r_lines_written);
    end
  end

  // MMIO responses: one cycle after the request, tag echoed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid      <= 1'b0;
      r_rd_data       <= '0;
      r_rd_user       <= '0;
      r_wr_resp_valid <= 1'b0;
      r_wr_resp_user  <= '0;
    end else begin
      r_rd_valid      <= mmio_read;
      r_wr_resp_valid <= mmio_write;
      if (mmio_read) begin
        r_rd_data <= w_rdata;
        r_rd_user <= mmio_user;
      end
      if (mmio_write) begin
        r_wr_resp_user <= mmio_user;
      end
    end
  end

  // Control FSM and burst generator.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= c_IDLE;
      r_done          <= 1'b0;
      r_base          <= '0;
      r_count         <= '0;
      r_lines_written <= '0;
      r_beats_left    <= '0;
      r_wr_write      <= 1'b0;
      r_wr_address    <= '0;
      r_wr_burstcount <= '0;
    end else begin
      if (w_base_wr) begin
        r_base <= ADDR_WIDTH'(mmio_writedata);
      end

      case (r_state)
        c_IDLE: begin
          if (w_start) begin
            r_count         <= w_new_count;
            r_done          <= 1'b0;
            r_lines_written <= '0;
            if (w_new_count != '0) begin
              r_state         <= c_BURST;
              r_wr_write      <= 1'b1;
              r_wr_address    <= r_base;
              r_wr_burstcount <= f_burst_len(w_new_count);
              r_beats_left    <= f_burst_len(w_new_count);
            end else begin
`ifdef HELLO_WORLD_DONE_FLAG_EN
              // Zero lines: only the flag beat, at base+0.
              r_state         <= c_FLAG;
              r_wr_write      <= 1'b1;
              r_wr_address    <= r_base;
              r_wr_burstcount <= c_BC_W'(1);
`else
              r_state         <= c_DONE;
              r_done          <= 1'b1;
`endif
            end
          end
        end

        c_BURST: begin
          if (w_accept) begin
            r_lines_written <= w_lw_next;
            if (r_beats_left == c_BC_W'(1)) begin
              if (w_lw_next == r_count) begin
`ifdef HELLO_WORLD_DONE_FLAG_EN
                r_state         <= c_FLAG;
                r_wr_address    <= r_base + ADDR_WIDTH'(r_count);
                r_wr_burstcount <= c_BC_W'(1);
`else
                r_state         <= c_DONE;
                r_wr_write      <= 1'b0;
                r_done          <= 1'b1;
`endif
              end else begin
                // Next burst starts back-to-back with no idle cycle.
                r_wr_address    <= r_base + ADDR_WIDTH'(w_lw_next);
                r_wr_burstcount <= f_burst_len(w_remaining);
                r_beats_left    <= f_burst_len(w_remaining);
              end
            end else begin
              r_beats_left <= r_beats_left - c_BC_W'(1);
            end
          end
        end

`ifdef HELLO_WORLD_DONE_FLAG_EN
        c_FLAG: begin
          if (w_accept) begin
            r_state    <= c_DONE;
            r_wr_write <= 1'b0;
            r_done     <= 1'b1;
          end
        end
`endif

        c_DONE: begin
          r_state <= c_IDLE;
        end

        default: begin
          r_state    <= c_IDLE;
          r_wr_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hello_world_burst_avalon.sv
//------------------------------------------------------------------------------
// Module      : tb_hello_world_burst_avalon
// Description : Self-checking bench for hello_world_burst_avalon. Expected
//               write beats are queued when a run is started and compared as
//               the DUT presents them. Honours HELLO_WORLD_DONE_FLAG_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hello_world_burst_avalon;

  localparam int AW  = 42;
  localparam int DW  = 512;
  localparam int MB  = 4;
  localparam int CW  = 16;
  localparam int BCW = $clog2(MB) + 1;

`ifdef HELLO_WORLD_DONE_FLAG_EN
  localparam int c_FLAG = 1;
`else
  localparam int c_FLAG = 0;
`endif

  localparam logic [103:0] c_HELLO = 104'h0021646c726f77206f6c6c6548;
  localparam logic [63:0]  c_DFH   = 64'h1000_0100_0000_0000;
  localparam logic [63:0]  c_ID_L  = 64'h9722_d433_75b6_1c66;
  localparam logic [63:0]  c_ID_H  = 64'h850a_dcc2_6ceb_4b22;

  typedef struct {
    logic [AW-1:0]  addr;
    logic [BCW-1:0] bc;
    logic [DW-1:0]  data;
  } beat_t;

  beat_t sb[$];

  logic            clk = 1'b0;
  logic            reset;
  logic [15:0]     mmio_address;
  logic            mmio_read;
  logic            mmio_write;
  logic [63:0]     mmio_writedata;
  logic [7:0]      mmio_user;
  logic            mmio_waitrequest;
  logic            mmio_readdatavalid;
  logic [63:0]     mmio_readdata;
  logic [7:0]      mmio_readresponseuser;
  logic [7:0]      mmio_writeresponseuser;
  logic            mmio_writeresponsevalid;
  logic            wr_write;
  logic [AW-1:0]   wr_address;
  logic [BCW-1:0]  wr_burstcount;
  logic [DW-1:0]   wr_writedata;
  logic [DW/8-1:0] wr_byteenable;
  logic            wr_waitrequest;
  logic            rd_read;

  int    n_cmp = 0;
  int    n_fail = 0;
  int    n_acc = 0;
  int    n_cyc = 0;
  int    last_acc_cyc = 0;
  bit    stall_en = 1'b0;

  hello_world_burst_avalon #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .mmio_address           (mmio_address),
    .mmio_read              (mmio_read),
    .mmio_write             (mmio_write),
    .mmio_writedata         (mmio_writedata),
    .mmio_user              (mmio_user),
    .mmio_waitrequest       (mmio_waitrequest),
    .mmio_readdatavalid     (mmio_readdatavalid),
    .mmio_readdata          (mmio_readdata),
    .mmio_readresponseuser  (mmio_readresponseuser),
    .mmio_writeresponseuser (mmio_writeresponseuser),
    .mmio_writeresponsevalid(mmio_writeresponsevalid),
    .wr_write               (wr_write),
    .wr_address             (wr_address),
    .wr_burstcount          (wr_burstcount),
    .wr_writedata           (wr_writedata),
    .wr_byteenable          (wr_byteenable),
    .wr_waitrequest         (wr_waitrequest),
    .rd_read                (rd_read)
  );

  always #5 clk = ~clk;

  always @(posedge clk) n_cyc <= n_cyc + 1;

  // Waitrequest driver: changes just after the edge, random when stalling.
  initial begin
    wr_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      wr_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Beat monitor: every presented beat must match the head of the queue.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (wr_write) begin
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL wr_extra_beat observed addr=%h bc=%0d expected=no beat", wr_address, wr_burstcount);
        end
        if (sb.size() != 0) begin
          e = sb[0];
          assert (wr_address === e.addr && wr_burstcount === e.bc &&
                  wr_writedata === e.data && wr_byteenable === {(DW/8){1'b1}}) else begin
            n_fail++;
            $error("FAIL wr_beat observed addr=%h bc=%0d lo=%h idx=%h expected addr=%h bc=%0d lo=%h idx=%h",
                   wr_address, wr_burstcount, wr_writedata[63:0], wr_writedata[DW-1 -: 32],
                   e.addr, e.bc, e.data[63:0], e.data[DW-1 -: 32]);
          end
          if (!wr_waitrequest) begin
            void'(sb.pop_front());
            n_acc++;
            last_acc_cyc = n_cyc;
          end
        end
      end
    end
  end

  // Reference model of one run: line i goes in the burst starting at i rounded
  // down to a multiple of MB, address taken modulo 2^AW.
  function automatic void push_run(input logic [AW-1:0] base, input int count);
    beat_t b;
    int    bs;
    for (int i = 0; i < count; i++) begin
      bs     = (i / MB) * MB;
      b.addr = base + AW'(bs);
      b.bc   = BCW'(((count - bs) < MB) ? (count - bs) : MB);
      b.data = '0;
      b.data[103:0]      = c_HELLO;
      b.data[DW-1 -: 32] = 32'(i);
      sb.push_back(b);
    end
    if (c_FLAG != 0) begin
      b.addr = base + AW'(count);
      b.bc   = BCW'(1);
      b.data = '0;
      b.data[31:0]  = 32'h600D_F00D;
      b.data[63:32] = 32'(count);
      sb.push_back(b);
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic csr_rd(input logic [15:0] a, input logic [7:0] tag, input logic [63:0] exp,
                        input logic [63:0] mask, input string name);
    @(negedge clk);
    mmio_address = a;
    mmio_user    = tag;
    mmio_read    = 1'b1;
    @(negedge clk);
    mmio_read    = 1'b0;
    chk({name, "_valid"}, 64'(mmio_readdatavalid), 64'd1);
    chk({name, "_tag"}, 64'(mmio_readresponseuser), 64'(tag));
    chk(name, mmio_readdata & mask, exp & mask);
  endtask

  task automatic csr_wr(input logic [15:0] a, input logic [63:0] d, input logic [7:0] tag,
                        input string name);
    @(negedge clk);
    mmio_address   = a;
    mmio_writedata = d;
    mmio_user      = tag;
    mmio_write     = 1'b1;
    @(negedge clk);
    mmio_write     = 1'b0;
    chk({name, "_wresp"}, 64'(mmio_writeresponsevalid), 64'd1);
    chk({name, "_wtag"}, 64'(mmio_writeresponseuser), 64'(tag));
  endtask

  task automatic wait_sb(input int budget, input string name);
    int i;
    i = 0;
    while (sb.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    n_cmp++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL %s_drain observed=%0d pending expected=0", name, sb.size());
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [63:0] status(input bit busy, input bit done, input int lw);
    return {busy, done, 30'b0, 32'(lw)};
  endfunction

  localparam logic [63:0] c_ALL = '1;
  localparam logic [63:0] c_TOP = 64'hC000_0000_0000_0000;

  initial begin
    int a0;
    int cs;
    reset          = 1'b1;
    mmio_address   = '0;
    mmio_read      = 1'b0;
    mmio_write     = 1'b0;
    mmio_writedata = '0;
    mmio_user      = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_wr_write", 64'(wr_write), 64'd0);
    chk("rst_rd_valid", 64'(mmio_readdatavalid), 64'd0);
    chk("rst_wresp_valid", 64'(mmio_writeresponsevalid), 64'd0);
    chk("rst_rd_read", 64'(rd_read), 64'd0);
    chk("mmio_waitreq", 64'(mmio_waitrequest), 64'd0);
    reset = 1'b0;

    // CSR map
    csr_rd(16'd0, 8'hA0, c_DFH, c_ALL, "dfh");
    @(negedge clk);
    chk("rd_valid_one_cycle", 64'(mmio_readdatavalid), 64'd0);
    csr_rd(16'd1, 8'hA1, c_ID_L, c_ALL, "afu_id_l");
    csr_rd(16'd2, 8'hA2, c_ID_H, c_ALL, "afu_id_h");
    csr_rd(16'd3, 8'hA3, 64'd0, c_ALL, "csr3");
    csr_rd(16'd4, 8'hA4, 64'd0, c_ALL, "csr4");
    csr_rd(16'd5, 8'hA5, 64'd0, c_ALL, "status_rst");

    // 10 lines at 0x1000, no stalls: 4+4+2, back-to-back
    csr_wr(16'd0, 64'h1000, 8'h10, "base1");
    push_run(AW'(64'h1000), 10);
    a0 = n_acc;
    csr_wr(16'd1, 64'd10, 8'h11, "start1");
    chk("first_beat_next_cycle", 64'(wr_write), 64'd1);
    cs = n_cyc;
    wait_sb(100, "run1");
    chk("run1_beats", 64'(n_acc - a0), 64'(10 + c_FLAG));
    chk("run1_no_bubble", 64'(last_acc_cyc - cs + 1), 64'(10 + c_FLAG));
    csr_rd(16'd5, 8'h12, status(1'b0, 1'b1, 10), c_ALL, "status_run1");

    // Same run under random backpressure
    stall_en = 1'b1;
    push_run(AW'(64'h1000), 10);
    a0 = n_acc;
    csr_wr(16'd1, 64'd10, 8'h20, "start2");
    wait_sb(400, "run2");
    stall_en = 1'b0;
    @(negedge clk);
    chk("run2_beats", 64'(n_acc - a0), 64'(10 + c_FLAG));
    csr_rd(16'd5, 8'h21, status(1'b0, 1'b1, 10), c_ALL, "status_run2");

    // Zero-length run
    push_run(AW'(64'h1000), 0);
    a0 = n_acc;
    csr_wr(16'd1, 64'd0, 8'h30, "start0");
    repeat (2) @(negedge clk);
    csr_rd(16'd5, 8'h31, status(1'b0, 1'b1, 0), c_ALL, "status_zero");
    wait_sb(10, "run0");
    chk("run0_beats", 64'(n_acc - a0), 64'(c_FLAG));

    // Base and start writes while busy are ignored
    csr_wr(16'd0, 64'h2000, 8'h40, "base3");
    push_run(AW'(64'h2000), 12);
    csr_wr(16'd1, 64'd12, 8'h41, "start3");
    csr_wr(16'd0, 64'h5000, 8'h42, "base_busy");
    csr_wr(16'd1, 64'd3, 8'h43, "start_busy");
    csr_rd(16'd5, 8'h44, status(1'b1, 1'b0, 0), c_TOP, "status_busy");
    wait_sb(100, "run3");
    csr_rd(16'd5, 8'h45, status(1'b0, 1'b1, 12), c_ALL, "status_run3");
    push_run(AW'(64'h2000), 2);
    csr_wr(16'd1, 64'd2, 8'h46, "start3b");
    wait_sb(50, "run3b");
    csr_rd(16'd5, 8'h47, status(1'b0, 1'b1, 2), c_ALL, "status_run3b");

    // Address wrap at the top of the line space
    csr_wr(16'd0, 64'h3FF_FFFF_FFFE, 8'h50, "base_wrap");
    push_run(AW'(64'h3FF_FFFF_FFFE), 6);
    csr_wr(16'd1, 64'd6, 8'h51, "start_wrap");
    wait_sb(100, "wrap");
    csr_rd(16'd5, 8'h52, status(1'b0, 1'b1, 6), c_ALL, "status_wrap");

    // Reset in the middle of a burst
    csr_wr(16'd0, 64'h3000, 8'h60, "base4");
    push_run(AW'(64'h3000), 20);
    csr_wr(16'd1, 64'd20, 8'h61, "start4");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_wr_write", 64'(wr_write), 64'd0);
    reset = 1'b0;
    sb.delete();
    csr_rd(16'd5, 8'h62, 64'd0, c_ALL, "status_after_rst");
    push_run(AW'(0), 3);
    a0 = n_acc;
    csr_wr(16'd1, 64'd3, 8'h63, "start5");
    wait_sb(50, "run5");
    chk("run5_beats", 64'(n_acc - a0), 64'(3 + c_FLAG));
    csr_rd(16'd5, 8'h64, status(1'b0, 1'b1, 3), c_ALL, "status_run5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
